// File: rtl/absorb_feeder.sv
// Absorb-mode driver for the sponge core: packs the word stream into padded blocks and runs one core pass per block.
// Optional watchdog on core_done is enabled by defining ABSORB_FEEDER_TIMEOUT_EN.
module absorb_feeder #(
    parameter int CWIDTH         = 320,
    parameter int RWIDTH         = 192,
    parameter int XWIDTH         = 128,
    parameter int BWIDTH         = 32,
    parameter int NUMBLOCKS      = 4,
    parameter int ROUND_COUNT    = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        cfg_empty,
    input  logic [1:0]                  cfg_domain,
    input  logic [ROUND_COUNT-1:0]      cfg_rounds,
    input  logic [CWIDTH-1:0]           c_in,
    input  logic [RWIDTH-1:0]           r_in,
    input  logic [XWIDTH-1:0]           x_in,
    input  logic [BWIDTH-1:0]           s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [BWIDTH*NUMBLOCKS-1:0] core_blocks,
    output logic [CWIDTH-1:0]           core_c,
    output logic [RWIDTH-1:0]           core_r,
    output logic [XWIDTH-1:0]           core_x,
    output logic                        core_finalize,
    output logic [1:0]                  core_domain,
    output logic [ROUND_COUNT-1:0]      core_rounds,
    output logic                        core_reset,
    output logic                        core_en,
    output logic                        core_squeez,
    output logic                        core_aof,
    input  logic [CWIDTH-1:0]           core_cout,
    input  logic [RWIDTH-1:0]           core_rout,
    input  logic [XWIDTH-1:0]           core_xout,
    input  logic                        core_done,
    output logic [CWIDTH-1:0]           c_out,
    output logic [RWIDTH-1:0]           r_out,
    output logic [XWIDTH-1:0]           x_out,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam int CNTW = (NUMBLOCKS > 1) ? $clog2(NUMBLOCKS) : 1;
    localparam logic [CNTW-1:0] LAST_SLOT = CNTW'(NUMBLOCKS - 1);

    typedef enum logic [2:0] {IDLE, FILL, KICK_PAD, KICK, RUN, WAIT, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [CNTW-1:0]        cnt_reg, cnt_next;
    logic                   fin_reg, fin_next;
    logic [1:0]             dom_reg, dom_next;
    logic [ROUND_COUNT-1:0] rnd_reg, rnd_next;
    logic [CWIDTH-1:0]      c_reg, c_next, c_out_reg, c_out_next;
    logic [RWIDTH-1:0]      r_reg, r_next, r_out_reg, r_out_next;
    logic [XWIDTH-1:0]      x_reg, x_next, x_out_reg, x_out_next;
    logic                   err_reg, err_next;
    logic                   blk_clear, word_we, pad_we, empty_pad;
    logic                   timeout;

`ifdef ABSORB_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_reg;

    // Cleared while in RUN so it reads zero on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (!reset || state_reg == RUN) begin
            timer_reg <= '0;
        end else if (state_reg == WAIT) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign timeout = (timer_reg == TW'(TIMEOUT_CYCLES));
`else
    // Watchdog compiled out; the comparison is constant-false and only keeps the parameter referenced.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Block register, one slot per word; slot k sits at core_blocks[k*BWIDTH +: BWIDTH].
    generate
        for (genvar gi = 0; gi < NUMBLOCKS; gi++) begin : g_slot
            localparam logic [CNTW-1:0] SLOT = CNTW'(gi);
            logic [BWIDTH-1:0] slot_reg, slot_next;
            logic              pad_here;

            if (gi == 0) begin : g_first
                assign pad_here = empty_pad;
            end else begin : g_rest
                assign pad_here = pad_we && (cnt_reg == CNTW'(gi - 1));
            end

            always_comb begin
                slot_next = slot_reg;
                if (blk_clear) begin
                    slot_next = '0;
                end else if (word_we && cnt_reg == SLOT) begin
                    slot_next = s_data;
                end else if (pad_here) begin
                    slot_next = BWIDTH'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            assign core_blocks[gi*BWIDTH +: BWIDTH] = slot_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fin_next   = fin_reg;
        dom_next   = dom_reg;
        rnd_next   = rnd_reg;
        c_next     = c_reg;
        r_next     = r_reg;
        x_next     = x_reg;
        c_out_next = c_out_reg;
        r_out_next = r_out_reg;
        x_out_next = x_out_reg;
        err_next   = err_reg;
        blk_clear  = 1'b0;
        word_we    = 1'b0;
        pad_we     = 1'b0;
        empty_pad  = 1'b0;
        s_ready    = 1'b0;
        core_en    = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    c_next     = c_in;
                    r_next     = r_in;
                    x_next     = x_in;
                    dom_next   = cfg_domain;
                    rnd_next   = cfg_rounds;
                    cnt_next   = '0;
                    fin_next   = 1'b0;
                    err_next   = 1'b0;
                    blk_clear  = 1'b1;
                    state_next = cfg_empty ? KICK_PAD : FILL;
                end
            end
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    word_we = 1'b1;
                    if (s_last || cnt_reg == LAST_SLOT) begin
                        // A short final block gets the 0x1 pad word right after the last data word.
                        pad_we     = s_last && (cnt_reg != LAST_SLOT);
                        fin_next   = s_last;
                        cnt_next   = '0;
                        state_next = KICK;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            KICK_PAD: begin
                empty_pad  = 1'b1;
                fin_next   = 1'b1;
                state_next = KICK;
            end
            KICK: begin
                state_next = RUN;
            end
            RUN: begin
                core_en    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                core_en = 1'b1;
                if (core_done) begin
                    c_next = core_cout;
                    r_next = core_rout;
                    x_next = core_xout;
                    if (fin_reg) begin
                        c_out_next = core_cout;
                        r_out_next = core_rout;
                        x_out_next = core_xout;
                        state_next = DONE;
                    end else begin
                        blk_clear  = 1'b1;
                        state_next = FILL;
                    end
                end else if (timeout) begin
                    // Abandon the block; report the last state that the core did deliver.
                    c_out_next = c_reg;
                    r_out_next = r_reg;
                    x_out_next = x_reg;
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            fin_reg   <= 1'b0;
            dom_reg   <= '0;
            rnd_reg   <= '0;
            c_reg     <= '0;
            r_reg     <= '0;
            x_reg     <= '0;
            c_out_reg <= '0;
            r_out_reg <= '0;
            x_out_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fin_reg   <= fin_next;
            dom_reg   <= dom_next;
            rnd_reg   <= rnd_next;
            c_reg     <= c_next;
            r_reg     <= r_next;
            x_reg     <= x_next;
            c_out_reg <= c_out_next;
            r_out_reg <= r_out_next;
            x_out_reg <= x_out_next;
            err_reg   <= err_next;
        end
    end

    assign core_reset    = ~reset | (state_reg == KICK);
    assign core_c        = c_reg;
    assign core_r        = r_reg;
    assign core_x        = x_reg;
    assign core_finalize = fin_reg;
    assign core_domain   = dom_reg;
    assign core_rounds   = rnd_reg;
    assign core_squeez   = 1'b0;
    assign core_aof      = 1'b0;
    assign c_out         = c_out_reg;
    assign r_out         = r_out_reg;
    assign x_out         = x_out_reg;
    assign busy          = (state_reg != IDLE);
    assign err           = err_reg;
endmodule

// File: tb/tb_absorb_feeder.sv
// Directed bench for absorb_feeder with a behavioural core model and a scoreboard of expected blocks and final states.
module tb_absorb_feeder;
    localparam int CW  = 320;
    localparam int RW  = 192;
    localparam int XW  = 128;
    localparam int BW  = 32;
    localparam int NB  = 4;
    localparam int RC  = 4;
    localparam int TO  = 1023;
    localparam int BLW = BW * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, start, cfg_empty, s_valid, s_last, s_ready;
    logic [1:0]     cfg_domain, core_domain;
    logic [RC-1:0]  cfg_rounds, core_rounds;
    logic [CW-1:0]  c_in, core_c, core_cout, c_out;
    logic [RW-1:0]  r_in, core_r, core_rout, r_out;
    logic [XW-1:0]  x_in, core_x, core_xout, x_out;
    logic [BW-1:0]  s_data;
    logic [BLW-1:0] core_blocks;
    logic           core_finalize, core_reset, core_en, core_squeez, core_aof, core_done;
    logic           busy, done, err;

    absorb_feeder #(
        .CWIDTH(CW), .RWIDTH(RW), .XWIDTH(XW), .BWIDTH(BW),
        .NUMBLOCKS(NB), .ROUND_COUNT(RC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_empty(cfg_empty),
        .cfg_domain(cfg_domain), .cfg_rounds(cfg_rounds),
        .c_in(c_in), .r_in(r_in), .x_in(x_in),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .core_blocks(core_blocks), .core_c(core_c), .core_r(core_r), .core_x(core_x),
        .core_finalize(core_finalize), .core_domain(core_domain), .core_rounds(core_rounds),
        .core_reset(core_reset), .core_en(core_en), .core_squeez(core_squeez), .core_aof(core_aof),
        .core_cout(core_cout), .core_rout(core_rout), .core_xout(core_xout), .core_done(core_done),
        .c_out(c_out), .r_out(r_out), .x_out(x_out),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [BLW-1:0] blocks;
        logic           fin;
        logic [CW-1:0]  c;
        logic [RW-1:0]  r;
        logic [XW-1:0]  x;
    } kick_t;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [RW-1:0] r;
        logic [XW-1:0] x;
    } st_t;

    kick_t         kick_q[$];
    st_t           done_q[$];
    logic [BW-1:0] words[64];
    int            checks = 0, errors = 0;
    int            kicks = 0, ready_cycles = 0, done_pulses = 0;
    int            cyc = 0, last_done_cyc = 0;
    int            lat = 0, lat_min = 1, lat_max = 4;
    bit            active = 0, hang = 0;
    logic [1:0]    cur_dom;
    logic [RC-1:0] cur_rnd;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in core: an arbitrary mixing of state, block and configuration.
    function automatic void core_f(input logic [CW-1:0] c, input logic [RW-1:0] r, input logic [XW-1:0] x,
                                   input logic [BLW-1:0] b, input logic fin, input logic [1:0] dom,
                                   input logic [RC-1:0] rnd, output logic [CW-1:0] co,
                                   output logic [RW-1:0] ro, output logic [XW-1:0] xo);
        co = {c[CW-2:0], c[CW-1]} ^ CW'(b);
        ro = r + RW'(b) + RW'(fin);
        xo = ~x ^ XW'({dom, rnd});
    endfunction

    always @(posedge clk) cyc++;

    // Core model and event counters, all sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            core_done = 1'b0;
            active    = 1'b0;
        end else begin
            core_done = 1'b0;
            if (core_reset) kicks++;
            if (s_ready) ready_cycles++;
            if (done) done_pulses++;
            if (!core_en) begin
                active = 1'b0;
            end else if (!active) begin
                kick_t k;
                active = 1'b1;
                lat    = $urandom_range(lat_max, lat_min);
                check("kick_pending", kick_q.size() != 0, 1'b1);
                if (kick_q.size() != 0) begin
                    k = kick_q.pop_front();
                    check("kick_blocks", core_blocks, k.blocks);
                    check("kick_fin_dom_rnd", {core_finalize, core_domain, core_rounds}, {k.fin, cur_dom, cur_rnd});
                    check("kick_state", {core_c, core_r, core_x}, {k.c, k.r, k.x});
                end
            end else if (!hang) begin
                lat--;
                if (lat == 0) begin
                    core_done     = 1'b1;
                    last_done_cyc = cyc;
                    core_f(core_c, core_r, core_x, core_blocks, core_finalize, core_domain, core_rounds,
                           core_cout, core_rout, core_xout);
                end
            end
        end
    end

    // Pushes the blocks and chained states a message should produce, then its final state.
    task automatic build(input int n, input bit empty, input logic [CW-1:0] c0,
                         input logic [RW-1:0] r0, input logic [XW-1:0] x0);
        logic [CW-1:0] c;
        logic [RW-1:0] r;
        logic [XW-1:0] x;
        kick_t         k;
        st_t           st;
        int            idx;
        c = c0; r = r0; x = x0; idx = 0;
        do begin
            k.blocks = '0;
            if (empty) begin
                k.blocks[BW-1:0] = 32'h0000_0001;
                k.fin = 1'b1;
            end else begin
                for (int s = 0; s < NB && idx < n; s++) begin
                    k.blocks[s*BW +: BW] = words[idx];
                    idx++;
                    if (idx == n && s < NB - 1) k.blocks[(s+1)*BW +: BW] = 32'h0000_0001;
                end
                k.fin = (idx == n);
            end
            k.c = c; k.r = r; k.x = x;
            kick_q.push_back(k);
            core_f(c, r, x, k.blocks, k.fin, cur_dom, cur_rnd, c, r, x);
        end while (!k.fin);
        st.c = c; st.r = r; st.x = x;
        done_q.push_back(st);
    endtask

    task automatic start_msg(input bit empty, input logic [CW-1:0] c0, input logic [RW-1:0] r0,
                             input logic [XW-1:0] x0);
        @(negedge clk);
        start = 1'b1; cfg_empty = empty; cfg_domain = cur_dom; cfg_rounds = cur_rnd;
        c_in = c0; r_in = r0; x_in = x0;
        @(negedge clk);
        start = 1'b0; cfg_empty = 1'b0; cfg_domain = ~cur_dom; cfg_rounds = ~cur_rnd;
        c_in = ~c0; r_in = ~r0; x_in = ~x0;
    endtask

    task automatic send_words(input string tag, input int from, input int to, input int n, input int pct);
        int i, budget;
        i = from; budget = 3000;
        while (i < to && budget > 0) begin
            @(negedge clk);
            budget--;
            s_valid = ($urandom_range(99, 0) < pct);
            s_data  = s_valid ? words[i] : 32'hdead_beef;
            s_last  = s_valid && (i == n - 1);
            if (s_valid && s_ready) i++;
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_data = 32'hdead_beef;
        check({tag, "_words_sent"}, i, to);
    endtask

    task automatic wait_done(input string tag, input logic exp_err, input bit timed);
        st_t e;
        int  k;
        k = 0;
        while (done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, done, 1'b1);
        if (timed) check({tag, "_done_latency"}, cyc, last_done_cyc + 1);
        check({tag, "_done_expected"}, done_q.size() != 0, 1'b1);
        if (done_q.size() != 0) begin
            e = done_q.pop_front();
            check({tag, "_final_state"}, {c_out, r_out, x_out}, {e.c, e.r, e.x});
        end
        check({tag, "_err_busy"}, {err, busy}, {exp_err, 1'b1});
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {done, busy}, 2'b00);
        $display("transaction %s complete at cycle %0d", tag, cyc);
    endtask

    initial begin
        logic [CW-1:0] c0;
        logic [RW-1:0] r0;
        logic [XW-1:0] x0;
        int k0, rd0, dp0, k;

        reset = 1'b0; start = 1'b0; cfg_empty = 1'b0; cfg_domain = '0; cfg_rounds = '0;
        c_in = '0; r_in = '0; x_in = '0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        core_done = 1'b0; core_cout = '0; core_rout = '0; core_xout = '0;
        for (int i = 0; i < 64; i++) words[i] = $urandom();
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, done, s_ready, core_en, core_reset, err, core_squeez, core_aof}, 8'b0000_1000);
        check("rst_core_bus", {core_blocks, core_finalize, core_domain, core_rounds}, '0);
        check("rst_state", {core_c, core_r, core_x, c_out, r_out, x_out}, '0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_core_reset", {core_reset, busy}, 2'b00);

        // One full block carrying s_last: no pad word.
        cur_dom = 2'd2; cur_rnd = 4'hc;
        c0 = {10{$urandom()}}; r0 = {6{$urandom()}}; x0 = {4{$urandom()}};
        k0 = kicks;
        build(4, 1'b0, c0, r0, x0);
        start_msg(1'b0, c0, r0, x0);
        send_words("msg4", 0, 4, 4, 100);
        wait_done("msg4", 1'b0, 1'b1);
        check("msg4_kicks", kicks - k0, 1);

        // Six words: one full block, then words 4,5 plus pad.
        cur_dom = 2'd1; cur_rnd = 4'h5;
        for (int i = 0; i < 64; i++) words[i] = $urandom();
        c0 = {10{$urandom()}}; r0 = {6{$urandom()}}; x0 = {4{$urandom()}};
        k0 = kicks;
        build(6, 1'b0, c0, r0, x0);
        start_msg(1'b0, c0, r0, x0);
        send_words("msg6", 0, 6, 6, 100);
        wait_done("msg6", 1'b0, 1'b1);
        check("msg6_kicks", kicks - k0, 2);

        // Empty message, with a second start while busy that must be ignored.
        cur_dom = 2'd3; cur_rnd = 4'h9;
        c0 = {10{$urandom()}}; r0 = {6{$urandom()}}; x0 = {4{$urandom()}};
        k0 = kicks; rd0 = ready_cycles;
        build(0, 1'b1, c0, r0, x0);
        start_msg(1'b1, c0, r0, x0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("empty", 1'b0, 1'b1);
        check("empty_no_ready", ready_cycles - rd0, 0);
        check("empty_kicks", kicks - k0, 1);

        // Random valid gaps and slower core over three blocks, then a short tail.
        cur_dom = 2'd0; cur_rnd = 4'h3; lat_max = 7;
        for (int i = 0; i < 64; i++) words[i] = $urandom();
        c0 = {10{$urandom()}}; r0 = {6{$urandom()}}; x0 = {4{$urandom()}};
        build(12, 1'b0, c0, r0, x0);
        start_msg(1'b0, c0, r0, x0);
        send_words("rand12", 0, 12, 12, 50);
        wait_done("rand12", 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) words[i] = $urandom();
        build(7, 1'b0, c0, r0, x0);
        start_msg(1'b0, c0, r0, x0);
        send_words("rand7", 0, 7, 7, 60);
        wait_done("rand7", 1'b0, 1'b1);

        // Reset while the core works on block 2: abort with no done pulse.
        lat_min = 20; lat_max = 20;
        for (int i = 0; i < 64; i++) words[i] = $urandom();
        c0 = {10{$urandom()}}; r0 = {6{$urandom()}}; x0 = {4{$urandom()}};
        dp0 = done_pulses;
        build(12, 1'b0, c0, r0, x0);
        start_msg(1'b0, c0, r0, x0);
        send_words("abort", 0, 8, 12, 80);
        k = 0;
        while (kick_q.size() != 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_block2_started", kick_q.size(), 1);
        repeat (3) @(negedge clk);
        check("abort_in_wait", {busy, core_en}, 2'b11);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ctrl", {busy, done, s_ready, core_en, core_reset, err}, 6'b000010);
        check("abort_zeroed", {core_blocks, core_c, core_r, core_x, c_out, r_out, x_out, core_finalize}, '0);
        reset = 1'b1;
        kick_q.delete();
        done_q.delete();
        @(negedge clk);
        check("abort_no_done", done_pulses - dp0, 0);
        lat_min = 1; lat_max = 4;
        cur_dom = 2'd2; cur_rnd = 4'h7;
        build(5, 1'b0, c0, r0, x0);
        start_msg(1'b0, c0, r0, x0);
        send_words("after_abort", 0, 5, 5, 70);
        wait_done("after_abort", 1'b0, 1'b1);

        // Core never answers.
        hang = 1'b1;
        c0 = {10{$urandom()}}; r0 = {6{$urandom()}}; x0 = {4{$urandom()}};
        dp0 = done_pulses;
        build(0, 1'b1, c0, r0, x0);
        void'(done_q.pop_back());
        start_msg(1'b1, c0, r0, x0);
        k = 0;
        while (core_en !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("hang_run_seen", core_en, 1'b1);
`ifdef ABSORB_FEEDER_TIMEOUT_EN
        done_q.push_back({c0, r0, x0});
        k = 0;
        while (done !== 1'b1 && k < TO + 50) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", k, TO + 2);
        wait_done("timeout", 1'b1, 1'b0);
        check("timeout_err_held", {err, busy}, 2'b10);
        hang = 1'b0;
`else
        repeat (TO + 100) @(negedge clk);
        check("hang_busy_held", {busy, core_en, done, err}, 4'b1100);
        check("hang_no_done", done_pulses - dp0, 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        hang = 1'b0;
        kick_q.delete();
        @(negedge clk);
        check("hang_reset_idle", busy, 1'b0);
`endif

        // Normal message afterwards; err must be clear again.
        cur_dom = 2'd1; cur_rnd = 4'he;
        for (int i = 0; i < 64; i++) words[i] = $urandom();
        c0 = {10{$urandom()}}; r0 = {6{$urandom()}}; x0 = {4{$urandom()}};
        build(9, 1'b0, c0, r0, x0);
        start_msg(1'b0, c0, r0, x0);
        send_words("final9", 0, 9, 9, 75);
        wait_done("final9", 1'b0, 1'b1);
        check("queues_drained", {kick_q.size() == 0, done_q.size() == 0}, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
